bus_arbiter_rr: RTL and testbench
=================================

BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 The block SHALL have parameter NUM_MASTERS, default 4, giving the number of bus requestors (2..16).
REQ-002 The block SHALL have parameter TIMEOUT, default 255, giving the maximum cycles of an unlocked tenure while others wait (2..65535).
REQ-003 The block SHALL have parameter OWNER_W, default 2, giving the width of Bowner; it equals ceil(log2(NUM_MASTERS)).
REQ-004 The block SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-005 The block SHALL have port bReset  input  1  synchronous, active-high reset (1 = reset).
REQ-006 The block SHALL have port Breq  input  NUM_MASTERS  per-master bus request, held high for the whole tenure.
REQ-007 The block SHALL have port Block  input  NUM_MASTERS  per-master lock; Block[i] is honoured only while i owns the bus.
REQ-008 The block SHALL have port Bgnt  output  NUM_MASTERS  registered grant, one-hot or zero.
REQ-009 The block SHALL have port Bbusy  output  1  high while any Bgnt bit is high.
REQ-010 The block SHALL have port Bowner  output  OWNER_W  index of the current or most recent owner.
REQ-011 The block SHALL have port Btimeout  output  1  one-cycle pulse on forced release.

Function
REQ-012 The block SHALL implement states IDLE, GRANT and HANDOFF.
REQ-013 In IDLE or HANDOFF with any Breq high, the block SHALL enter GRANT next cycle with Bgnt one-hot to the winner (1-cycle latency).
REQ-014 The block SHALL select the winner as the first requester searching upward from (Bowner+1) mod NUM_MASTERS, wrapping past NUM_MASTERS-1 to 0.
REQ-015 In IDLE or HANDOFF with no Breq high, the block SHALL go to or stay in IDLE with Bgnt=0.
REQ-016 In GRANT, when Breq[Bowner] is sampled low, the block SHALL enter HANDOFF next cycle with Bgnt=0.
REQ-017 HANDOFF SHALL last exactly one cycle, leaving a guaranteed one-cycle dead gap between any two grants for tri-state bus turnaround.
REQ-018 The block SHALL run a tenure counter that clears on entry to GRANT and increments each GRANT cycle, saturating at TIMEOUT.
REQ-019 When count = TIMEOUT-1, another Breq is high and Block[Bowner] = 0, the block SHALL enter HANDOFF next cycle and pulse Btimeout for that HANDOFF cycle.
REQ-020 With Block[Bowner] = 1, the block SHALL never preempt; the counter saturates and release occurs only via Breq drop.
REQ-021 A preempted master still requesting SHALL receive the lowest priority in the following arbitration.
REQ-022 A lone owner with no competing request SHALL never be preempted, regardless of the counter value.
REQ-023 Breq[Bowner] low and timeout in the same cycle SHALL produce a normal release with Btimeout = 0.
REQ-024 Breq or Block changes from non-owners during GRANT SHALL have no effect until the next arbitration.
REQ-025 Bowner SHALL update only on entry to GRANT and SHALL hold through HANDOFF and IDLE.

Reset
REQ-026 bReset = 1 at a rising edge SHALL force IDLE, Bgnt = 0, Bbusy = 0, Btimeout = 0, counter = 0 and Bowner = NUM_MASTERS-1, so master 0 wins first.
REQ-027 Reset asserted during GRANT or HANDOFF SHALL drop Bgnt the following cycle, with no Btimeout pulse.
REQ-028 The first arbitration SHALL occur on the first edge with bReset = 0 and a request present.

Verification (NUM_MASTERS = 4, TIMEOUT = 8)
REQ-029 Reset, then Breq = 4'b1010 -> next cycle Bgnt = 4'b0010, Bowner = 1.
REQ-030 Owner 1 drops Breq while Breq[3] is high -> Bgnt = 0 for one cycle (HANDOFF), then Bgnt = 4'b1000, Bowner = 3.
REQ-031 Owner 3 finishes while Breq = 4'b0011 -> the search wraps and grants master 0 (Bgnt = 4'b0001).
REQ-032 Master 2 holds Breq with Block = 0 while Breq[0] is high -> after 8 GRANT cycles, Btimeout = 1 for one cycle with Bgnt = 0, then Bgnt = 4'b0001.
REQ-033 Same as REQ-032 with Block[2] = 1 -> no preemption for 20+ cycles; master 0 is granted only after the HANDOFF that follows Breq[2] falling.
REQ-034 bReset = 1 during GRANT -> Bgnt = 0 and Bowner = 3 next cycle; with Breq = 4'b1111 after release, master 0 is granted.

Source files
------------

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with lockable tenures, tenure timeout and a one-cycle
// dead gap (HANDOFF) between consecutive grants for tri-state turnaround.
module bus_arbiter_rr #(
  parameter int NUM_MASTERS = 4,
  parameter int TIMEOUT     = 255,
  parameter int OWNER_W     = 2
) (
  input  logic                   clk,
  input  logic                   bReset,
  input  logic [NUM_MASTERS-1:0] Breq,
  input  logic [NUM_MASTERS-1:0] Block,
  output logic [NUM_MASTERS-1:0] Bgnt,
  output logic                   Bbusy,
  output logic [OWNER_W-1:0]     Bowner,
  output logic                   Btimeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, GRANT, HANDOFF} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [OWNER_W-1:0]     owner;
  logic [OWNER_W-1:0]     winner;
  logic [CNT_W-1:0]       cnt;
  logic                   to_flag;
  logic                   to_nxt;
  logic [NUM_MASTERS-1:0] owner_oh;
  logic                   owner_req;
  logic                   owner_lock;
  logic                   contend;
  logic                   expire;
  logic                   found;
  int                     idx;

  always_comb begin
    owner_oh   = NUM_MASTERS'(1) << owner;
    owner_req  = |(Breq & owner_oh);
    owner_lock = |(Block & owner_oh);
    contend    = |(Breq & ~owner_oh);
    expire     = (cnt == CNT_W'(TIMEOUT - 1)) && contend && !owner_lock;
  end

  // Search upward from owner+1, wrapping, so the last owner ends up lowest priority.
  always_comb begin
    winner = owner;
    found  = 1'b0;
    idx    = 0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = int'(owner) + i;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!found && Breq[OWNER_W'(idx)]) begin
        found  = 1'b1;
        winner = OWNER_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bReset) begin
      state   <= IDLE;
      owner   <= OWNER_W'(NUM_MASTERS - 1);
      cnt     <= '0;
      to_flag <= 1'b0;
    end else begin
      state   <= state_nxt;
      to_flag <= to_nxt;
      if (state != GRANT && state_nxt == GRANT) begin
        owner <= winner;
        cnt   <= '0;
      end else if (state == GRANT && cnt != CNT_W'(TIMEOUT)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    to_nxt    = 1'b0;
    case (state)
      IDLE, HANDOFF: state_nxt = found ? GRANT : IDLE;
      GRANT: begin
        if (!owner_req) begin
          state_nxt = HANDOFF;
        end else if (expire) begin
          state_nxt = HANDOFF;
          to_nxt    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Bgnt     = (state == GRANT) ? owner_oh : '0;
    Bbusy    = (state == GRANT);
    Btimeout = (state == HANDOFF) && to_flag;
    Bowner   = owner;
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr with NUM_MASTERS=4, TIMEOUT=8.
module tb_bus_arbiter_rr;

  logic       clk = 1'b0;
  logic       bReset;
  logic [3:0] Breq;
  logic [3:0] Block;
  logic [3:0] Bgnt;
  logic       Bbusy;
  logic [1:0] Bowner;
  logic       Btimeout;

  int checks = 0;
  int errors = 0;

  bus_arbiter_rr #(.NUM_MASTERS(4), .TIMEOUT(8), .OWNER_W(2)) dut (
    .clk(clk), .bReset(bReset), .Breq(Breq), .Block(Block),
    .Bgnt(Bgnt), .Bbusy(Bbusy), .Bowner(Bowner), .Btimeout(Btimeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] gnt, input logic [1:0] own,
                           input logic tmo);
    check({tag, ".gnt"}, 32'(Bgnt), 32'(gnt));
    check({tag, ".busy"}, 32'(Bbusy), 32'(|gnt));
    check({tag, ".owner"}, 32'(Bowner), 32'(own));
    check({tag, ".tmo"}, 32'(Btimeout), 32'(tmo));
  endtask

  initial begin
    bReset = 1'b1; Breq = 4'b0000; Block = 4'b0000;
    tick(); tick();
    check_all("reset", 4'b0000, 2'd3, 1'b0);

    // first arbitration right after reset release
    bReset = 1'b0; Breq = 4'b1010;
    tick();
    check_all("first_grant", 4'b0010, 2'd1, 1'b0);

    // owner 1 releases, master 3 waits
    Breq = 4'b1000;
    tick();
    check_all("handoff_1to3", 4'b0000, 2'd1, 1'b0);
    tick();
    check_all("grant_3", 4'b1000, 2'd3, 1'b0);

    // owner 3 releases, search wraps to master 0
    Breq = 4'b0011;
    tick();
    check_all("handoff_3to0", 4'b0000, 2'd3, 1'b0);
    tick();
    check_all("wrap_grant_0", 4'b0001, 2'd0, 1'b0);

    // hand the bus to master 2
    Breq = 4'b0100;
    tick();
    check_all("handoff_0to2", 4'b0000, 2'd0, 1'b0);
    tick();
    check_all("grant_2", 4'b0100, 2'd2, 1'b0);

    // unlocked tenure with master 0 waiting: preempted after 8 grant cycles
    Breq = 4'b0101; Block = 4'b0000;
    for (int i = 0; i < 7; i++) begin
      tick();
      check_all("unlocked_hold", 4'b0100, 2'd2, 1'b0);
    end
    tick();
    check_all("timeout_pulse", 4'b0000, 2'd2, 1'b1);
    tick();
    check_all("after_timeout", 4'b0001, 2'd0, 1'b0);

    // lone owner is never preempted
    Breq = 4'b0001;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_all("lone_owner", 4'b0001, 2'd0, 1'b0);
    end

    // locked tenure for master 2
    Breq = 4'b0100;
    tick();
    check_all("handoff_0to2b", 4'b0000, 2'd0, 1'b0);
    tick();
    check_all("grant_2b", 4'b0100, 2'd2, 1'b0);
    Breq = 4'b0101; Block = 4'b0100;
    for (int i = 0; i < 22; i++) begin
      tick();
      check_all("locked_hold", 4'b0100, 2'd2, 1'b0);
    end
    Breq = 4'b0001;
    tick();
    check_all("locked_release", 4'b0000, 2'd2, 1'b0);
    tick();
    check_all("grant_0_after_lock", 4'b0001, 2'd0, 1'b0);

    // reset in the middle of a tenure
    Block = 4'b0000; Breq = 4'b1111; bReset = 1'b1;
    tick();
    check_all("reset_in_grant", 4'b0000, 2'd3, 1'b0);
    bReset = 1'b0;
    tick();
    check_all("grant_after_reset", 4'b0001, 2'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
